// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, counter width and address legality
// helper for the data-memory responder.
package dmem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // A byte address is legal when it is word aligned and falls inside the
  // 2**addr_w word array; nothing above the array is aliased back into it.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] upper;
    upper = addr >> (addr_w + 2);
    return (addr[1:0] == 2'b00) && (upper == 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: 2**ADDR_W x 32 data RAM with synchronous byte-lane writes
// and a registered read port. Contents are never reset.
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_q;

  // Write the enabled byte lanes and capture the addressed word on a read
  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side target for the CPU data port. Accepts one
// load/store at a time, inserts WAIT_CYCLES wait states, commits to the
// data array on the edge entering RESP and holds the response until the
// requester takes it. Illegal (misaligned or out-of-range) accesses report
// resp_err and never touch the array.
// Optional feature: define DMEM_BYTE_EN to add req_be[3:0] byte-lane
// enables for stores; without it every store writes the whole word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]        req_be,
`endif
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("dmem_responder: DATA_W must be 32");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_check
    $error("dmem_responder: WAIT_CYCLES must be within 0..15");
  end

  localparam logic [CNT_W-1:0] WaitInit = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, err_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;

  logic               accept, commit;
  logic [3:0]         in_be;
  logic               cur_we, cur_err;
  logic [ADDR_W-1:0]  cur_idx;
  logic [31:0]        cur_wdata;
  logic [3:0]         cur_be;
  logic               ram_we, ram_re;
  logic [31:0]        ram_rdata;

`ifdef DMEM_BYTE_EN
  assign in_be = req_be;
`else
  assign in_be = 4'hF;
`endif

  assign req_ready = (state_q == IDLE);
  assign accept    = req_ready && req_valid;

  // With zero wait states the commit happens on the acceptance edge itself,
  // so the live request is used in IDLE and the latched copy everywhere else
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_err   = !addr_legal(req_addr, ADDR_W);
      cur_idx   = req_addr[ADDR_W+1:2];
      cur_wdata = req_wdata;
      cur_be    = in_be;
    end else begin
      cur_we    = we_q;
      cur_err   = err_q;
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
  end

  // Next-state logic: IDLE -> WAIT -> RESP, flagging the edge that enters RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WaitInit;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and response-qualifying flags; reset wins over a handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q  <= req_we;
        err_q <= !addr_legal(req_addr, ADDR_W);
      end
    end
  end

  // Request payload captured at acceptance so later req_* changes are ignored
  always_ff @(posedge clock) begin
    if (accept) begin
      idx_q   <= req_addr[ADDR_W+1:2];
      wdata_q <= req_wdata;
      be_q    <= in_be;
    end
  end

  // A reset on the commit edge abandons the access, so it also blocks the write
  assign ram_we = commit && !reset && cur_we  && !cur_err;
  assign ram_re = commit && !reset && !cur_we && !cur_err;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clock   (clock),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .be_i    (cur_be),
    .addr_i  (cur_idx),
    .wdata_i (cur_wdata),
    .rdata_o (ram_rdata)
  );

  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? ram_rdata : '0;

endmodule
